// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_arbiter
//  Purpose  : Two-master (m0/m1) arbiter in front of a single-issue data bus.
//             At most one read or write is issued per cycle. A master may hold
//             the bus with its lock input for up to LOCK_MAX transactions.
//             Read data returns one cycle after the read is issued and is
//             routed back to the master that issued the read.
//  Config   : DATA_BUS_ARB_ROUND_ROBIN_EN defined   -> round-robin on contention
//             DATA_BUS_ARB_ROUND_ROBIN_EN undefined -> m0 wins on contention
//  Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   // master 0
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   // master 1
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   // bus side
   output logic        bus_r_en,
   output logic [31:0] bus_r_addr,
   input  logic [31:0] bus_r_data,
   output logic        bus_w_en,
   output logic [31:0] bus_w_addr,
   output logic [31:0] bus_w_data,
   output logic [3:0]  bus_w_strb
);

   localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_M0 = 2'd1,
      OWN_M1 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic [7:0]  lock_cnt_inc;
   logic        rtag_vld_q, rtag_vld_d;
   logic        rtag_m1_q, rtag_m1_d;

   logic        gnt0, gnt1;
   logic        prefer_m1;      // on contention in IDLE, m1 wins when set
   logic        force_rel0;     // m0 lock cut off at LOCK_MAX this cycle
   logic        force_rel1;     // m1 lock cut off at LOCK_MAX this cycle

   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;

   // Arbitration: owner-only grants while locked, otherwise sole requester or
   // contention winner. Grants are held off entirely while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         case (state_q)
            OWN_M0:  gnt0 = m0_req;
            OWN_M1:  gnt1 = m1_req;
            default: begin
               if (m0_req && m1_req) begin
                  gnt0 = ~prefer_m1;
                  gnt1 = prefer_m1;
               end else begin
                  gnt0 = m0_req;
                  gnt1 = m1_req;
               end
            end
         endcase
      end
   end

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   // Bus mux: pass the granted master's payload through; read-side and
   // write-side fields stay zero unless that kind of access is issued.
   always_comb begin
      sel_we     = gnt1 ? m1_we    : m0_we;
      sel_addr   = gnt1 ? m1_addr  : m0_addr;
      sel_wdata  = gnt1 ? m1_wdata : m0_wdata;
      sel_wstrb  = gnt1 ? m1_wstrb : m0_wstrb;
      bus_r_en   = (gnt0 | gnt1) & ~sel_we;
      bus_w_en   = (gnt0 | gnt1) &  sel_we;
      bus_r_addr = bus_r_en ? sel_addr  : 32'h0;
      bus_w_addr = bus_w_en ? sel_addr  : 32'h0;
      bus_w_data = bus_w_en ? sel_wdata : 32'h0;
      bus_w_strb = bus_w_en ? sel_wstrb : 4'h0;
   end

   // Lock FSM next state: enter on a locked grant, count owner grants, leave
   // on an unlocked grant, on an idle unlocked cycle, or at LOCK_MAX.
   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      force_rel0   = 1'b0;
      force_rel1   = 1'b0;
      lock_cnt_inc = lock_cnt_q + 8'd1;
      case (state_q)
         OWN_M0: begin
            if (gnt0) begin
               if (!m0_lock) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
               end else if (lock_cnt_inc >= LOCK_LIMIT) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
                  force_rel0 = 1'b1;
               end else begin
                  lock_cnt_d = lock_cnt_inc;
               end
            end else if (!m0_lock) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end
         end
         OWN_M1: begin
            if (gnt1) begin
               if (!m1_lock) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
               end else if (lock_cnt_inc >= LOCK_LIMIT) begin
                  state_d    = IDLE;
                  lock_cnt_d = 8'd0;
                  force_rel1 = 1'b1;
               end else begin
                  lock_cnt_d = lock_cnt_inc;
               end
            end else if (!m1_lock) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end
         end
         default: begin
            // A limit of one means the locking grant is already the last one.
            if (gnt0 && m0_lock) begin
               if (LOCK_LIMIT <= 8'd1) begin
                  force_rel0 = 1'b1;
               end else begin
                  state_d    = OWN_M0;
                  lock_cnt_d = 8'd1;
               end
            end else if (gnt1 && m1_lock) begin
               if (LOCK_LIMIT <= 8'd1) begin
                  force_rel1 = 1'b1;
               end else begin
                  state_d    = OWN_M1;
                  lock_cnt_d = 8'd1;
               end
            end
         end
      endcase
   end

   // Read tag: remember who issued this cycle's read so next cycle's data
   // goes only to that master.
   always_comb begin
      rtag_vld_d = bus_r_en;
      rtag_m1_d  = gnt1;
   end

   // State, lock counter and read tag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_cnt_q <= 8'd0;
         rtag_vld_q <= 1'b0;
         rtag_m1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         rtag_vld_q <= rtag_vld_d;
         rtag_m1_q  <= rtag_m1_d;
      end
   end

   assign m0_rvalid = rtag_vld_q & ~rtag_m1_q;
   assign m1_rvalid = rtag_vld_q &  rtag_m1_q;
   assign m0_rdata  = m0_rvalid ? bus_r_data : 32'h0;
   assign m1_rdata  = m1_rvalid ? bus_r_data : 32'h0;

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
   logic rr_ptr_q, rr_ptr_d;

   // Round-robin pointer: points at the master that did not get the last
   // grant, which also hands the bus over after a LOCK_MAX cut-off.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (force_rel0) begin
         rr_ptr_d = 1'b1;
      end else if (force_rel1) begin
         rr_ptr_d = 1'b0;
      end else if (gnt0) begin
         rr_ptr_d = 1'b1;
      end else if (gnt1) begin
         rr_ptr_d = 1'b0;
      end
   end

   // Pointer register, resets to m0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign prefer_m1 = rr_ptr_q;
`else
   logic handover_m1_q, handover_m1_d;

   // Fixed priority with a one-shot hand-over: after m0 is cut off at
   // LOCK_MAX, m1 wins the next IDLE arbitration; any IDLE grant clears it.
   always_comb begin
      handover_m1_d = handover_m1_q;
      if (force_rel0) begin
         handover_m1_d = 1'b1;
      end else if (force_rel1 || ((state_q == IDLE) && (gnt0 || gnt1))) begin
         handover_m1_d = 1'b0;
      end
   end

   // Hand-over flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         handover_m1_q <= 1'b0;
      end else begin
         handover_m1_q <= handover_m1_d;
      end
   end

   assign prefer_m1 = handover_m1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_bus_arbiter
//  Purpose  : Directed, table-driven bench for data_bus_arbiter (LOCK_MAX=3).
//             Expectations follow DATA_BUS_ARB_ROUND_ROBIN_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic        req;
      logic        we;
      logic        lock;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } mreq_t;

   typedef struct {
      string       nm;
      mreq_t       m0;
      mreq_t       m1;
      logic [31:0] rdata;
      logic [1:0]  gnt;   // {m1, m0}
      logic [1:0]  rv;    // {m1, m0}
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        bus_r_en, bus_w_en;
   logic [31:0] bus_r_addr, bus_r_data, bus_w_addr, bus_w_data;
   logic [3:0]  bus_w_strb;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   data_bus_arbiter #(.LOCK_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .bus_r_en(bus_r_en), .bus_r_addr(bus_r_addr), .bus_r_data(bus_r_data),
      .bus_w_en(bus_w_en), .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data),
      .bus_w_strb(bus_w_strb)
   );

   function automatic mreq_t nop();
      mreq_t r;
      r = '0;
      return r;
   endfunction

   function automatic mreq_t rdq(input logic [31:0] a, input logic lk);
      mreq_t r;
      r = '0;
      r.req = 1'b1; r.lock = lk; r.addr = a;
      return r;
   endfunction

   function automatic mreq_t wrq(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic lk);
      mreq_t r;
      r = '0;
      r.req = 1'b1; r.we = 1'b1; r.lock = lk; r.addr = a; r.wdata = d; r.strb = s;
      return r;
   endfunction

   function automatic mreq_t lock_only();
      mreq_t r;
      r = '0;
      r.lock = 1'b1;
      return r;
   endfunction

   function automatic vec_t mk(input string nm, input mreq_t a, input mreq_t b,
                               input logic [31:0] rd, input logic [1:0] g,
                               input logic [1:0] rv);
      vec_t v;
      v.nm = nm; v.m0 = a; v.m1 = b; v.rdata = rd; v.gnt = g; v.rv = rv;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      m0_req = v.m0.req; m0_we = v.m0.we; m0_lock = v.m0.lock;
      m0_addr = v.m0.addr; m0_wdata = v.m0.wdata; m0_wstrb = v.m0.strb;
      m1_req = v.m1.req; m1_we = v.m1.we; m1_lock = v.m1.lock;
      m1_addr = v.m1.addr; m1_wdata = v.m1.wdata; m1_wstrb = v.m1.strb;
      bus_r_data = v.rdata;
   endtask

   // Expected bus fields are derived from the expected grant and the inputs.
   task automatic check_vec(input vec_t v);
      mreq_t        s;
      logic         any;
      logic         er, ew;
      logic [101:0] exp_bus, act_bus;
      logic [65:0]  exp_rd, act_rd;
      s   = v.gnt[1] ? v.m1 : v.m0;
      any = |v.gnt;
      er  = any & ~s.we;
      ew  = any & s.we;
      exp_bus = {er, ew, er ? s.addr : 32'h0, ew ? s.addr : 32'h0,
                 ew ? s.wdata : 32'h0, ew ? s.strb : 4'h0};
      act_bus = {bus_r_en, bus_w_en, bus_r_addr, bus_w_addr, bus_w_data, bus_w_strb};
      exp_rd  = {v.rv, v.rv[1] ? v.rdata : 32'h0, v.rv[0] ? v.rdata : 32'h0};
      act_rd  = {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata};
      cmp({v.nm, ".gnt"},   {126'h0, m1_gnt, m0_gnt}, {126'h0, v.gnt});
      cmp({v.nm, ".rdata"}, {62'h0, act_rd},  {62'h0, exp_rd});
      cmp({v.nm, ".bus"},   {26'h0, act_bus}, {26'h0, exp_bus});
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v);
      #3;
      check_vec(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;

      // Simple read, then write with no rvalid.
      tbl.push_back(mk("rd0_grant", rdq(32'h0000_0010, 0), nop(), 32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("rd0_data",  nop(), nop(), 32'hCAFE_BABE, 2'b00, 2'b01));
      tbl.push_back(mk("wr1", nop(), wrq(32'h2000_0004, 32'h1234_5678, 4'h3, 0),
                       32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("wr1_after", nop(), nop(), 32'hDEAD_0001, 2'b00, 2'b00));
      // Back-to-back reads from different masters.
      tbl.push_back(mk("b2b_m0", rdq(32'h100, 0), nop(), 32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("b2b_m1", nop(), rdq(32'h200, 0), 32'h1111_1111, 2'b10, 2'b01));
      tbl.push_back(mk("b2b_tail", nop(), nop(), 32'h2222_2222, 2'b00, 2'b10));
      // Contention for four cycles, both masters reading.
      tbl.push_back(mk("cont0", rdq(32'h300, 0), rdq(32'h400, 0), 32'hA000_0000,
                       2'b01, 2'b00));
      tbl.push_back(mk("cont1", rdq(32'h300, 0), rdq(32'h400, 0), 32'hA000_0001,
                       RR ? 2'b10 : 2'b01, 2'b01));
      tbl.push_back(mk("cont2", rdq(32'h300, 0), rdq(32'h400, 0), 32'hA000_0002,
                       2'b01, RR ? 2'b10 : 2'b01));
      tbl.push_back(mk("cont3", rdq(32'h300, 0), rdq(32'h400, 0), 32'hA000_0003,
                       RR ? 2'b10 : 2'b01, 2'b01));
      tbl.push_back(mk("cont_tail", nop(), nop(), 32'hA000_0004, 2'b00,
                       RR ? 2'b10 : 2'b01));
      // m1 locks for LOCK_MAX=3 grants while m0 waits; m0 then wins.
      tbl.push_back(mk("lk1_c0", nop(), wrq(32'h500, 32'h55, 4'hF, 1), 32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lk1_c1", rdq(32'h600, 0), wrq(32'h500, 32'h55, 4'hF, 1), 32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lk1_c2", rdq(32'h600, 0), wrq(32'h500, 32'h55, 4'hF, 1), 32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lk1_c3", rdq(32'h600, 0), wrq(32'h500, 32'h55, 4'hF, 1), 32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("lk1_tail", nop(), nop(), 32'hB0B0_B0B0, 2'b00, 2'b01));
      // m0 locks to the limit; m1 must get the next arbitration.
      tbl.push_back(mk("lk0_c0", wrq(32'h700, 32'h77, 4'hF, 1), nop(), 32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("lk0_c1", wrq(32'h700, 32'h77, 4'hF, 1), wrq(32'h800, 32'h88, 4'h1, 0),
                       32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("lk0_c2", wrq(32'h700, 32'h77, 4'hF, 1), wrq(32'h800, 32'h88, 4'h1, 0),
                       32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("lk0_hand", wrq(32'h700, 32'h77, 4'hF, 1), wrq(32'h800, 32'h88, 4'h1, 0),
                       32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lk0_relock", wrq(32'h700, 32'h77, 4'hF, 1), nop(), 32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("own0_block", lock_only(), wrq(32'h800, 32'h88, 4'h1, 0),
                       32'h0, 2'b00, 2'b00));
      tbl.push_back(mk("own0_exit", nop(), wrq(32'h800, 32'h88, 4'h1, 0), 32'h0, 2'b00, 2'b00));
      tbl.push_back(mk("idle_m1", nop(), wrq(32'h800, 32'h88, 4'h1, 0), 32'h0, 2'b10, 2'b00));
      // Lock released by an unlocked grant before the limit.
      tbl.push_back(mk("lk1_enter", nop(), wrq(32'h840, 32'h99, 4'h8, 1), 32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lk1_unlock", rdq(32'h900, 0), wrq(32'h840, 32'h99, 4'h8, 0),
                       32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("post_unlock", rdq(32'h900, 0), wrq(32'h844, 32'h9A, 4'h4, 0),
                       32'h0, 2'b01, 2'b00));
      tbl.push_back(mk("post_tail", nop(), nop(), 32'hC0C0_C0C0, 2'b00, 2'b01));
      // Lock without request in IDLE is ignored.
      tbl.push_back(mk("lock_noreq", lock_only(), wrq(32'h880, 32'h1, 4'h2, 0), 32'h0, 2'b10, 2'b00));
      tbl.push_back(mk("lock_noreq_chk", nop(), wrq(32'h884, 32'h2, 4'h2, 0), 32'h0, 2'b10, 2'b00));

      // Reset state: a pending request must not be granted while in reset.
      rst_n = 1'b0;
      r = mk("reset", rdq(32'h10, 0), wrq(32'h20, 32'h3, 4'h1, 0), 32'hFFFF_FFFF, 2'b00, 2'b00);
      drive(r);
      #3;
      check_vec(r);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(mk("idle", nop(), nop(), 32'h0, 2'b00, 2'b00));
      rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // Reset in the cycle after a read grant: the read must be dropped.
      apply(mk("rst_rd", rdq(32'hA00, 0), nop(), 32'h0, 2'b01, 2'b00));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      r = mk("rst_mid", nop(), rdq(32'hB00, 0), 32'hFFFF_FFFF, 2'b00, 2'b00);
      drive(r);
      #1;
      check_vec(r);
      @(negedge clk);
      #3;
      check_vec(mk("rst_hold", nop(), rdq(32'hB00, 0), 32'hFFFF_FFFF, 2'b00, 2'b00));
      @(negedge clk);
      drive(mk("idle", nop(), nop(), 32'h0, 2'b00, 2'b00));
      rst_n = 1'b1;
      apply(mk("rst_rel0", nop(), nop(), 32'h5555_5555, 2'b00, 2'b00));
      apply(mk("rst_rel1", nop(), nop(), 32'h6666_6666, 2'b00, 2'b00));
      apply(mk("rst_newreq", nop(), rdq(32'hC00, 0), 32'h0, 2'b10, 2'b00));
      apply(mk("rst_newdata", nop(), nop(), 32'h7777_7777, 2'b00, 2'b10));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8, the maximum number of consecutive transactions one master may hold the bus via its lock input (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have, for each master X in {m0, m1}, the following requester-side ports:
  - mX_req, input, 1: transaction request.
  - mX_we, input, 1: 1 = write, 0 = read.
  - mX_lock, input, 1: request to keep ownership for the next transaction.
  - mX_addr, input, 32: byte address.
  - mX_wdata, input, 32: write data.
  - mX_wstrb, input, 4: write byte strobes.
REQ-005 SHALL have, for each master X, these outputs:
  - mX_gnt, output, 1: transaction accepted this cycle.
  - mX_rvalid, output, 1: read data valid.
  - mX_rdata, output, 32: read data.
REQ-006 SHALL have the following bus-side ports, which connect to the core side of the data bus mux:
  - bus_r_en, output, 1.
  - bus_r_addr, output, 32.
  - bus_r_data, input, 32.
  - bus_w_en, output, 1.
  - bus_w_addr, output, 32.
  - bus_w_data, output, 32.
  - bus_w_strb, output, 4.

Function
REQ-007 SHALL issue at most one transaction per cycle, either a read or a write, never both.
REQ-008 SHALL assert mX_gnt combinationally in the same cycle as mX_req when X wins arbitration; a master SHALL hold its request and payload stable until granted.
REQ-009 SHALL, for the granted master, drive bus_r_en = req & ~we, or bus_w_en = req & we, with the address, data and strobes passed through unmodified.
REQ-010 SHALL drive all bus_* outputs to zero when no grant is issued in a cycle.
REQ-011 SHALL treat bus_r_data as valid exactly one cycle after bus_r_en is asserted.
REQ-012 SHALL register a read owner tag at grant time and assert the owner's mX_rvalid in the following cycle, with mX_rdata = bus_r_data.
REQ-013 SHALL drive the non-owner's rdata to zero; writes SHALL produce no rvalid.
REQ-014 SHALL implement a state machine with states IDLE, OWN_M0 and OWN_M1:
  - IDLE: normal arbitration (REQ-015).
  - IDLE -> OWN_X: when X is granted with mX_lock = 1; lock counter set to 1.
  - OWN_X: only X may be granted; each grant to X increments the counter.
  - OWN_X -> IDLE: on a grant with mX_lock = 0, on a cycle with mX_lock = 0 and no mX_req, or on the grant that brings the counter to LOCK_MAX.
REQ-015 SHALL, in IDLE:
  - grant the sole requester if only one master requests;
  - resolve simultaneous requests per REQ-020;
  - grant nothing if neither master requests.
REQ-016 SHALL, whenever a lock is force-released at LOCK_MAX, give the other master priority for the next arbitration if it is requesting.
REQ-017 SHALL allow a read grant in the same cycle as a pending rvalid (back-to-back reads), including to a different master; tags SHALL not mix between masters.
REQ-018 SHALL ignore mX_lock when mX_req is 0 in IDLE.

Reset
REQ-019 SHALL, while rst_n is low, immediately force:
  - state IDLE;
  - lock counter 0;
  - priority pointer to m0;
  - read tag invalid;
  - m0_rvalid = m1_rvalid = 0;
  - m0_gnt = m1_gnt = 0;
  - all bus_* outputs 0.
  An in-flight read SHALL be dropped, with no rvalid after reset release.

Configuration
REQ-020 SHALL use macro DATA_BUS_ARB_ROUND_ROBIN_EN to select the contention policy:
  - Defined: on simultaneous requests in IDLE, grant the master the priority pointer names; after each grant the pointer moves to the other master.
  - Undefined: m0 always wins on contention, and the pointer logic SHALL be absent.
  - In both cases, the LOCK_MAX hand-over of REQ-016 SHALL apply.

Verification
REQ-021 SHALL cover simple read: m0 reads 0x0000_0010, bus_r_data = 0xCAFEBABE next cycle -> m0_gnt in cycle 0, m0_rvalid = 1 and m0_rdata = 0xCAFEBABE in cycle 1, m1_rvalid = 0.
REQ-022 SHALL cover contention with macro defined: m0 and m1 request for 4 cycles -> grants alternate m0, m1, m0, m1; with macro undefined -> m0, m0, m0, m0.
REQ-023 SHALL cover lock limit: LOCK_MAX = 3, m1 requests with lock held, m0 also requesting -> m1 granted 3 times, then m0 granted in the 4th cycle.
REQ-024 SHALL cover back-to-back reads: m0 read then m1 read in consecutive cycles -> m0_rvalid in cycle 1, m1_rvalid in cycle 2, each with the correct bus_r_data.
REQ-025 SHALL cover write: m1 writes 0x1234_5678 to 0x2000_0004 with strobe 0x3 -> bus_w_en = 1 and fields passed through, no rvalid.
REQ-026 SHALL cover reset mid-read: rst_n driven low in the cycle after a read grant -> no rvalid at any point, all outputs 0 until the next request.
